// File: rtl/voice_allocator_if.sv
// Event handshake between the keyboard event decoder (master) and the voice allocator (slave).
interface voice_allocator_if;
    logic        ev_valid;
    logic        ev_ready;
    logic        ev_note_on;
    logic [6:0]  ev_key;
    logic [31:0] ev_freq;
    logic [31:0] ev_volume;

    modport master (
        output ev_valid, ev_note_on, ev_key, ev_freq, ev_volume,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_note_on, ev_key, ev_freq, ev_volume,
        output ev_ready
    );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: one-voice-per-cycle scan, oldest-voice stealing.
// Optional sustain pedal support is enabled by defining VOICE_ALLOC_SUSTAIN_EN.
module voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int AGE_W      = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
`ifdef VOICE_ALLOC_SUSTAIN_EN
    input  logic                       sustain,
`endif
    voice_allocator_if.slave           ev,
    output logic [NUM_VOICES*32-1:0]   frequencies,
    output logic [NUM_VOICES*32-1:0]   voice_volumes,
    output logic [NUM_VOICES-1:0]      voice_active,
    output logic                       steal
);

    localparam int                IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [AGE_W-1:0]  AGE_MAX  = '1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] scan_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] old_idx;
    logic [AGE_W-1:0] old_age;
    logic [IDX_W-1:0] target;

    logic             note_on_q;
    logic [6:0]       key_q;
    logic [31:0]      freq_q;
    logic [31:0]      vol_q;

    logic [31:0]      freq_r [NUM_VOICES];
    logic [31:0]      vol_r  [NUM_VOICES];
    logic [6:0]       key_r  [NUM_VOICES];
    logic [AGE_W-1:0] age_r  [NUM_VOICES];
    logic [NUM_VOICES-1:0] active_r;
    logic [NUM_VOICES-1:0] held_r;

    logic             sus_now;
    logic             release_now;

`ifdef VOICE_ALLOC_SUSTAIN_EN
    logic sustain_q;
    logic release_pend;

    // A pedal release seen while busy is remembered and served on the next IDLE cycle.
    assign sus_now     = sustain;
    assign release_now = (state == ST_IDLE) && (release_pend || (sustain_q && !sustain));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sustain_q    <= 1'b0;
            release_pend <= 1'b0;
        end else begin
            sustain_q    <= sustain;
            release_pend <= (state != ST_IDLE) && (release_pend || (sustain_q && !sustain));
        end
    end
`else
    assign sus_now     = 1'b0;
    assign release_now = 1'b0;
`endif

    assign ev.ev_ready   = (state == ST_IDLE) && !release_now;
    assign target        = free_found ? free_idx : old_idx;
    assign voice_active  = active_r;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign frequencies[g*32 +: 32]   = freq_r[g];
        assign voice_volumes[g*32 +: 32] = vol_r[g];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            scan_idx   <= '0;
            free_found <= 1'b0;
            free_idx   <= '0;
            old_idx    <= '0;
            old_age    <= '0;
            note_on_q  <= 1'b0;
            key_q      <= '0;
            freq_q     <= '0;
            vol_q      <= '0;
            active_r   <= '0;
            held_r     <= '0;
            steal      <= 1'b0;
            // NOTE: the voice table is reset explicitly because outputs must read 0 straight out of reset.
            for (int v = 0; v < NUM_VOICES; v++) begin
                freq_r[v] <= '0;
                vol_r[v]  <= '0;
                key_r[v]  <= '0;
                age_r[v]  <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
            steal <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (release_now) begin
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (held_r[v]) begin
                                vol_r[v]    <= '0;
                                active_r[v] <= 1'b0;
                                age_r[v]    <= '0;
                                held_r[v]   <= 1'b0;
                            end
                        end
                    end else if (ev.ev_valid) begin
                        note_on_q  <= ev.ev_note_on;
                        key_q      <= ev.ev_key;
                        freq_q     <= ev.ev_freq;
                        vol_q      <= ev.ev_volume;
                        scan_idx   <= '0;
                        free_found <= 1'b0;
                        state      <= ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    if (!active_r[scan_idx] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    // Strict compare keeps the lowest index on equal ages.
                    if (scan_idx == '0 || age_r[scan_idx] > old_age) begin
                        old_idx <= scan_idx;
                        old_age <= age_r[scan_idx];
                    end
                    if (scan_idx == LAST_IDX) begin
                        state <= ST_COMMIT;
                    end else begin
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end

                ST_COMMIT: begin
                    state <= ST_IDLE;
                    if (note_on_q) begin
                        steal <= !free_found;
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (v == int'(target)) begin
                                freq_r[v]   <= freq_q;
                                vol_r[v]    <= vol_q;
                                key_r[v]    <= key_q;
                                active_r[v] <= 1'b1;
                                age_r[v]    <= '0;
                                held_r[v]   <= 1'b0;
                            end else if (active_r[v] && age_r[v] != AGE_MAX) begin
                                age_r[v] <= age_r[v] + AGE_W'(1);
                            end
                        end
                    end else begin
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (active_r[v] && key_r[v] == key_q) begin
                                if (sus_now) begin
                                    held_r[v] <= 1'b1;
                                end else begin
                                    vol_r[v]    <= '0;
                                    active_r[v] <= 1'b0;
                                    age_r[v]    <= '0;
                                    held_r[v]   <= 1'b0;
                                end
                            end
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: vector table, directed corner cases, random vs reference model.
module tb_voice_allocator;

    localparam int NV = 8;

    logic clk;
    logic reset_n;
    bit   sus_level;

    logic [NV*32-1:0] frequencies;
    logic [NV*32-1:0] voice_volumes;
    logic [NV-1:0]    voice_active;
    logic             steal;

    voice_allocator_if bus();

    voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
`ifdef VOICE_ALLOC_SUSTAIN_EN
        .sustain       (sus_level),
`endif
        .ev            (bus),
        .frequencies   (frequencies),
        .voice_volumes (voice_volumes),
        .voice_active  (voice_active),
        .steal         (steal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] actual, input logic [255:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference model: voice table updated directly from the allocation rules.
    bit        m_active [NV];
    bit [6:0]  m_key    [NV];
    bit [31:0] m_freq   [NV];
    bit [31:0] m_vol    [NV];
    int        m_age    [NV];
    bit        m_held   [NV];

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_active[i] = 0; m_key[i] = 0; m_freq[i] = 0;
            m_vol[i] = 0; m_age[i] = 0; m_held[i] = 0;
        end
    endtask

    task automatic model_release(input int i);
        m_vol[i] = 0; m_active[i] = 0; m_age[i] = 0; m_held[i] = 0;
    endtask

    task automatic model_event(input bit on, input bit [6:0] key, input bit [31:0] f,
                               input bit [31:0] v, output bit stl);
        int tgt;
        stl = 0;
        if (on) begin
            tgt = -1;
            for (int i = NV - 1; i >= 0; i--) if (!m_active[i]) tgt = i;
            if (tgt < 0) begin
                stl = 1;
                tgt = 0;
                for (int i = 1; i < NV; i++) if (m_age[i] > m_age[tgt]) tgt = i;
            end
            for (int i = 0; i < NV; i++) begin
                if (i == tgt) begin
                    m_freq[i] = f; m_vol[i] = v; m_key[i] = key;
                    m_active[i] = 1; m_age[i] = 0; m_held[i] = 0;
                end else if (m_active[i]) begin
                    m_age[i] = (m_age[i] + 1 > 255) ? 255 : m_age[i] + 1;
                end
            end
        end else begin
            for (int i = 0; i < NV; i++) begin
                if (m_active[i] && m_key[i] == key) begin
                    if (sus_level) m_held[i] = 1;
                    else model_release(i);
                end
            end
        end
    endtask

    task automatic compare_model(input string tag);
        logic [NV*32-1:0] ef, ev;
        logic [NV-1:0]    ea;
        for (int i = 0; i < NV; i++) begin
            ef[i*32 +: 32] = m_freq[i];
            ev[i*32 +: 32] = m_vol[i];
            ea[i]          = m_active[i];
        end
        check({tag, "_freq"},   frequencies,   ef);
        check({tag, "_vol"},    voice_volumes, ev);
        check({tag, "_active"}, voice_active,  ea);
    endtask

    // One full transaction: wait for ready, handshake, then verify timing and result.
    task automatic send_event(input string tag, input bit on, input bit [6:0] key,
                              input bit [31:0] f, input bit [31:0] v);
        int n;
        bit stl;
        n = 0;
        @(negedge clk);
        while (!bus.ev_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check({tag, "_ready_timeout"}, 1'b0, 1'b1);
        bus.ev_valid   = 1'b1;
        bus.ev_note_on = on;
        bus.ev_key     = key;
        bus.ev_freq    = f;
        bus.ev_volume  = v;
        @(posedge clk);
        #1 bus.ev_valid = 1'b0;
        repeat (NV) @(posedge clk);
        #1 check({tag, "_busy_before_commit"}, bus.ev_ready, 1'b0);
        @(posedge clk);
        #1;
        check({tag, "_ready_after_commit"}, bus.ev_ready, 1'b1);
        model_event(on, key, f, v, stl);
        check({tag, "_steal"}, steal, stl);
        compare_model(tag);
        if (stl) begin
            @(posedge clk);
            #1 check({tag, "_steal_one_cycle"}, steal, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("reset_freq",   frequencies,   '0);
        check("reset_vol",    voice_volumes, '0);
        check("reset_active", voice_active,  '0);
        check("reset_steal",  steal,         1'b0);
        check("reset_ready",  bus.ev_ready,  1'b1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit        on;
        bit [6:0]  key;
        bit [31:0] freq;
        bit [31:0] vol;
        bit [7:0]  exp_active;
        bit        exp_steal;
        int        chk_voice;
        bit [31:0] chk_freq;
        bit [31:0] chk_vol;
    } vec_t;

    vec_t vecs [17];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int acc_cycles[$];
        bit [6:0] k;

        reset_n        = 1'b0;
        sus_level      = 1'b0;
        bus.ev_valid   = 1'b0;
        bus.ev_note_on = 1'b0;
        bus.ev_key     = '0;
        bus.ev_freq    = '0;
        bus.ev_volume  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        vecs[0]  = '{1, 7'd60, 32'h1000, 32'h80, 8'h01, 0, 0, 32'h1000, 32'h80};
        vecs[1]  = '{0, 7'd60, 32'h0,    32'h0,  8'h00, 0, 0, 32'h1000, 32'h0};
        for (int i = 1; i <= 8; i++) begin
            k = 7'(i);
            vecs[i+1] = '{1, k, 32'(i) << 8, 32'(i) + 32'h40, 8'((1 << i) - 1), 0, i - 1,
                          32'(i) << 8, 32'(i) + 32'h40};
        end
        vecs[10] = '{1, 7'd9,  32'h900, 32'h49, 8'hFF, 1, 0, 32'h900, 32'h49};
        vecs[11] = '{1, 7'd11, 32'hB00, 32'h4B, 8'hFF, 1, 1, 32'hB00, 32'h4B};
        vecs[12] = '{0, 7'd3,  32'h0,   32'h0,  8'hFB, 0, 2, 32'h300, 32'h0};
        vecs[13] = '{1, 7'd10, 32'hA00, 32'h4A, 8'hFF, 0, 2, 32'hA00, 32'h4A};
        vecs[14] = '{0, 7'd99, 32'h0,   32'h0,  8'hFF, 0, 0, 32'h900, 32'h49};
        vecs[15] = '{1, 7'd5,  32'h555, 32'h55, 8'hFF, 1, 3, 32'h555, 32'h55};
        vecs[16] = '{0, 7'd5,  32'h0,   32'h0,  8'hE7, 0, 3, 32'h555, 32'h0};

        for (int i = 0; i < 17; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            send_event(tag, vecs[i].on, vecs[i].key, vecs[i].freq, vecs[i].vol);
            check({tag, "_tbl_active"}, voice_active, vecs[i].exp_active);
            check({tag, "_tbl_freq"}, frequencies[vecs[i].chk_voice*32 +: 32], vecs[i].chk_freq);
            check({tag, "_tbl_vol"}, voice_volumes[vecs[i].chk_voice*32 +: 32], vecs[i].chk_vol);
        end

        // Continuous ev_valid: accepts must be spaced exactly NV+2 cycles apart.
        @(negedge clk);
        bus.ev_valid   = 1'b1;
        bus.ev_note_on = 1'b0;
        bus.ev_key     = 7'd99;
        for (int c = 0; c < 45; c++) begin
            if (bus.ev_ready) acc_cycles.push_back(c);
            @(negedge clk);
        end
        bus.ev_valid = 1'b0;
        check("stream_accept_count", acc_cycles.size(), 5);
        for (int i = 1; i < acc_cycles.size(); i++)
            check("stream_accept_gap", acc_cycles[i] - acc_cycles[i-1], NV + 2);
        repeat (12) @(posedge clk);
        #1 compare_model("stream");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            send_event($sformatf("rnd%0d", i), ($urandom_range(0, 9) < 7),
                       7'($urandom_range(0, 11)), $urandom, $urandom);
        end

        // Reset in the middle of a scan drops the event and clears outputs at once.
        @(negedge clk);
        bus.ev_valid   = 1'b1;
        bus.ev_note_on = 1'b1;
        bus.ev_key     = 7'd20;
        bus.ev_freq    = 32'hABC;
        bus.ev_volume  = 32'h12;
        @(posedge clk);
        #1 bus.ev_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midscan_freq",   frequencies,   '0);
        check("midscan_vol",    voice_volumes, '0);
        check("midscan_active", voice_active,  '0);
        check("midscan_ready",  bus.ev_ready,  1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (12) @(posedge clk);
        #1;
        check("midscan_dropped", voice_active, '0);
        check("midscan_ready_after", bus.ev_ready, 1'b1);

`ifdef VOICE_ALLOC_SUSTAIN_EN
        do_reset();
        @(negedge clk);
        sus_level = 1'b1;
        send_event("sus_on",  1'b1, 7'd5, 32'h5000, 32'h77);
        send_event("sus_off", 1'b0, 7'd5, 32'h0,    32'h0);
        check("sus_held_active", voice_active[0], 1'b1);
        @(negedge clk);
        sus_level = 1'b0;
        #1 check("sus_release_ready", bus.ev_ready, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < NV; i++) if (m_held[i]) model_release(i);
        check("sus_release_active", voice_active[0], 1'b0);
        check("sus_release_vol", voice_volumes[31:0], 32'h0);
        check("sus_release_ready_back", bus.ev_ready, 1'b1);
        compare_model("sus_release");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
